// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_t;

  localparam int unsigned IRQ_TIMER   = 0;
  localparam int unsigned IRQ_EXT     = 1;
  localparam int unsigned IRQ_NUM_SRC = 4;

endpackage

// File: rtl/irq_if.sv
// Request/ack/done handshake between the interrupt controller and the core's trap logic.
interface irq_if #(
  parameter int unsigned NUM_SRC = 4
);
  localparam int unsigned ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] irq_vec;
  logic               irq_req;
  logic [ID_W-1:0]    irq_id;
  logic               irq_ack;
  logic               irq_done;

  modport master (output irq_vec, irq_req, irq_id, input irq_ack, irq_done);
  modport slave  (input irq_vec, irq_req, irq_id, output irq_ack, irq_done);
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; valid_c flags any active input.
module irq_prio_enc #(
  parameter int unsigned NUM_SRC = 4,
  localparam int unsigned ID_W = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid_c,
  output logic [ID_W-1:0]    index_c
);

  // Scan from the top down so the lowest set index is written last.
  always_comb begin
    valid_c = |req;
    index_c = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) index_c = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Pending/enable latching, fixed-priority arbitration and request FSM towards the core.
// Build option: define IRQ_SYNC_EN to put a 2-flop synchronizer on every src_i bit.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned         NUM_SRC    = IRQ_NUM_SRC,
  parameter logic [NUM_SRC-1:0]  EDGE_MASK  = NUM_SRC'(1),
  parameter logic [NUM_SRC-1:0]  ENABLE_RST = NUM_SRC'(3)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               en_we,
  input  logic [NUM_SRC-1:0] en_wdata,
  output logic [NUM_SRC-1:0] en_q,
  output logic [NUM_SRC-1:0] pend_q,
  irq_if.master              core
);

  localparam int unsigned ID_W = $clog2(NUM_SRC);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_REQ     = REQ;
  localparam logic [1:0] ST_SERVICE = SERVICE;

  logic [1:0]         state_q, state_d;
  logic [NUM_SRC-1:0] vec_q, vec_d;
  logic               req_q, req_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_SRC-1:0] pend_clr;
  logic [NUM_SRC-1:0] pend_set;
  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] hist_q;
  logic               cand_valid;
  logic [ID_W-1:0]    cand_idx;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = src_i;
`endif

  // Edge sources need a 0->1 transition; level sources set on every high sample.
  assign pend_set = src_s & ~(hist_q & EDGE_MASK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      pend_q <= '0;
      en_q   <= ENABLE_RST;
    end else begin
      hist_q <= src_s;
      pend_q <= (pend_q & ~pend_clr) | pend_set;
      if (en_we) en_q <= en_wdata;
    end
  end

  irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .req     (pend_q & en_q),
    .valid_c (cand_valid),
    .index_c (cand_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      req_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      req_q   <= req_d;
      id_q    <= id_d;
    end
  end

  // The request is held without preemption until ack or until its enable is removed.
  always_comb begin
    state_d  = state_q;
    vec_d    = '0;
    req_d    = 1'b0;
    id_d     = id_q;
    pend_clr = '0;
    case (state_q)
      ST_IDLE: begin
        if (cand_valid) begin
          id_d    = cand_idx;
          vec_d   = NUM_SRC'(1) << cand_idx;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (core.irq_ack) begin
          pend_clr = NUM_SRC'(1) << id_q;
          state_d  = ST_SERVICE;
        end else if (!en_q[id_q]) begin
          state_d = ST_IDLE;
        end else begin
          vec_d = vec_q;
          req_d = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (core.irq_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign core.irq_vec = vec_q;
  assign core.irq_req = req_q;
  assign core.irq_id  = id_q;

endmodule
